// File: rtl/prbs_burst_ctrl.sv
// ---------------------------------------------------------------------------
// prbs_burst_ctrl
//
// Emits PRBS data as framed bursts on a valid/ready stream. Each accepted
// start command optionally reseeds the generator, streams burst_len words
// (the final one flagged with out_last), waits gap_len idle cycles and then
// pulses done. abort ends a burst early with an aborted pulse.
//
// Stream handshake: a word transfers in every cycle where out_valid and
// out_ready are both 1. out_valid never depends on out_ready, and while
// out_valid=1 and out_ready=0 the word and out_last hold stable.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   start        burst request, sampled only while idle
//   burst_len    words in the burst, captured on start
//   gap_len      idle cycles after the last word, captured on start
//   restart_seq  reload the generator to LFSR_INIT before the burst
//   abort        terminate the current burst
//   out_data     PRBS word straight from the generator
//   out_valid    out_data is valid
//   out_ready    sink accepts the word
//   out_last     final word of the burst
//   busy         burst in progress (LOAD, RUN or GAP)
//   done         one-cycle pulse on normal completion
//   aborted      one-cycle pulse after an abort
//   word_count   words accepted in the current or most recent burst
//
// Also contains lfsr_prbs_gen, the PRBS word generator used by the
// sequencer.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// lfsr_prbs_gen
//
// Advances an LFSR by DATA_WIDTH steps per enabled cycle. data_out is the
// word of bits the LFSR will shift out on the next advance, first bit in the
// MSB (LSB when REVERSE is set), optionally inverted.
//
// Ports:
//   clk, rst   clock and synchronous reset (reloads LFSR_INIT)
//   enable     advance the sequence by one word
//   data_out   current word
// ---------------------------------------------------------------------------
module lfsr_prbs_gen #(
  parameter int                    LFSR_WIDTH  = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 31'h10000001,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = {LFSR_WIDTH{1'b1}},
  parameter string                 LFSR_CONFIG = "FIBONACCI",
  parameter int                    REVERSE     = 0,
  parameter int                    INVERT      = 1,
  parameter int                    DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam bit IS_GALOIS = (LFSR_CONFIG == "GALOIS");

  logic [LFSR_WIDTH-1:0] state;
  logic [LFSR_WIDTH-1:0] state_next;
  logic [DATA_WIDTH-1:0] word_bits;
  logic                  fb;

  // Unrolled DATA_WIDTH single-bit steps. Bit 0 of the polynomial is the
  // implied constant term and is not a tap.
  always_comb begin
    state_next = state;
    word_bits  = '0;
    fb         = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      fb = state_next[LFSR_WIDTH-1];
      if (IS_GALOIS) begin
        state_next = {state_next[LFSR_WIDTH-2:0], fb};
        for (int j = 1; j < LFSR_WIDTH; j++) begin
          if (LFSR_POLY[j]) state_next[j] = state_next[j] ^ fb;
        end
      end else begin
        for (int j = 1; j < LFSR_WIDTH; j++) begin
          if (LFSR_POLY[j]) fb = fb ^ state_next[j-1];
        end
        state_next = {state_next[LFSR_WIDTH-2:0], fb};
      end
      word_bits[DATA_WIDTH-1-i] = fb;
    end
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      data_out[i] = (REVERSE != 0) ? word_bits[DATA_WIDTH-1-i] : word_bits[i];
    end
    if (INVERT != 0) data_out = ~data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_INIT;
    end else if (enable) begin
      state <= state_next;
    end
  end

endmodule

module prbs_burst_ctrl #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    LEN_WIDTH   = 16,
  parameter int                    GAP_WIDTH   = 8,
  parameter int                    LFSR_WIDTH  = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 31'h10000001,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = {LFSR_WIDTH{1'b1}},
  parameter string                 LFSR_CONFIG = "FIBONACCI",
  parameter int                    REVERSE     = 0,
  parameter int                    INVERT      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic [GAP_WIDTH-1:0]  gap_len,
  input  logic                  restart_seq,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [LEN_WIDTH-1:0]  word_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [LEN_WIDTH-1:0] len_q;
  logic [GAP_WIDTH-1:0] gap_q;
  logic [GAP_WIDTH-1:0] gap_cnt;
  logic                 reseed_q;
  logic                 gen_reseed;
  logic                 handshake;
  logic                 last_word;
  logic                 done_n;
  logic                 aborted_n;

  assign handshake = out_valid & out_ready;
  assign last_word = (word_count == len_q - 1'b1);

  lfsr_prbs_gen #(
    .LFSR_WIDTH  (LFSR_WIDTH),
    .LFSR_POLY   (LFSR_POLY),
    .LFSR_INIT   (LFSR_INIT),
    .LFSR_CONFIG (LFSR_CONFIG),
    .REVERSE     (REVERSE),
    .INVERT      (INVERT),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_gen (
    .clk      (clk),
    .rst      (rst | gen_reseed),
    .enable   (handshake),
    .data_out (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b1;
    gen_reseed = 1'b0;
    done_n     = 1'b0;
    aborted_n  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = LOAD;
      end
      LOAD: begin
        // The reseed lands on the same edge that enters RUN, so the first
        // word of a restarted burst is the LFSR_INIT word.
        gen_reseed = reseed_q;
        if (len_q != '0) begin
          state_n = RUN;
        end else if (gap_q != '0) begin
          state_n = GAP;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      RUN: begin
        out_valid = 1'b1;
        out_last  = last_word;
        if (out_ready && last_word) begin
          if (gap_q != '0) begin
            state_n = GAP;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Abort overrides any completion decided in the same cycle.
    if (abort && (state != IDLE)) begin
      state_n   = IDLE;
      done_n    = 1'b0;
      aborted_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      gap_q      <= '0;
      reseed_q   <= 1'b0;
      gap_cnt    <= '0;
      word_count <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      done    <= done_n;
      aborted <= aborted_n;
      if ((state == IDLE) && start) begin
        len_q      <= burst_len;
        gap_q      <= gap_len;
        reseed_q   <= restart_seq;
        word_count <= '0;
      end else if (handshake) begin
        word_count <= word_count + 1'b1;
      end
      // Preloaded with gap_len-1 outside GAP, so the count runs down to
      // zero over exactly gap_len GAP cycles.
      if (state != GAP) begin
        gap_cnt <= gap_q - 1'b1;
      end else begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

endmodule
